// File: rtl/rtc_bus_if.sv
// Sequencer-side request/response and RTC multiplexed AD-bus signals of the RTC bus driver.
// The sequencer uses the master view; the bus driver uses the slave view.
interface rtc_bus_if;
    logic       activa;
    logic       escribe;
    logic [7:0] dir;
    logic [7:0] dato;
    logic       fin;
    logic [7:0] dato_leido;
    logic       ocupado;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;

    modport master (
        output activa, escribe, dir, dato, ad_in,
        input  fin, dato_leido, ocupado, ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n
    );

    modport slave (
        input  activa, escribe, dir, dato, ad_in,
        output fin, dato_leido, ocupado, ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n
    );
endinterface

// File: rtl/rtc_bus_driver.sv
// Multiplexed-AD RTC bus driver: one timed write or read per request (address
// phase, gap, data phase, done, recovery), with every output registered.
module rtc_bus_driver #(
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_GAP   = 10
) (
    input  logic        clk,
    input  logic        reset,
    rtc_bus_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        GAP     = 3'd2,
        DATA    = 3'd3,
        DONE    = 3'd4,
        RECOVER = 3'd5
    } state_t;

    localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
    localparam logic [7:0] GAP_LD   = 8'(T_GAP - 1);

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [7:0] dir_q, dato_q;
    logic       esc_q;
    logic       latch_en, capture;

    logic       cs_n_d, rd_n_d, wr_n_d, ad_n_d, ad_oe_d, fin_d, ocupado_d;
    logic [7:0] ad_out_d;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the simulator runs the blocks in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // NOTE: the request latches carry no reset; they are loaded at acceptance
    // before anything reads them, so a reset would only add routing.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            dir_q  <= bus.dir;
            dato_q <= bus.dato;
            esc_q  <= bus.escribe;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        latch_en  = 1'b0;
        capture   = 1'b0;
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        ad_n_d    = 1'b1;
        ad_oe_d   = 1'b0;
        ad_out_d  = '0;
        fin_d     = 1'b0;
        ocupado_d = 1'b1;
        case (state)
            IDLE: begin
                ocupado_d = 1'b0;
                if (bus.activa) begin
                    latch_en = 1'b1;
                    cnt_d    = PULSE_LD;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = dir_q;
                if (cnt == 8'd0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            GAP: begin
                // Address stays on the bus through the gap to meet RTC hold time.
                ad_oe_d  = 1'b1;
                ad_out_d = dir_q;
                if (cnt == 8'd0) begin
                    state_d = DATA;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            DATA: begin
                cs_n_d = 1'b0;
                if (esc_q) begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = dato_q;
                end else begin
                    rd_n_d = 1'b0;
                end
                if (cnt == 8'd0) begin
                    capture = ~esc_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            DONE: begin
                fin_d    = 1'b1;
                ad_oe_d  = esc_q;
                ad_out_d = esc_q ? dato_q : 8'd0;
                state_d  = RECOVER;
                cnt_d    = GAP_LD;
            end
            RECOVER: begin
                // activa is deliberately not looked at until IDLE is reached.
                if (cnt == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            default: begin
                ocupado_d = 1'b0;
                state_d   = IDLE;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cs_n       <= 1'b1;
            bus.rd_n       <= 1'b1;
            bus.wr_n       <= 1'b1;
            bus.ad_n       <= 1'b1;
            bus.ad_oe      <= 1'b0;
            bus.ad_out     <= '0;
            bus.fin        <= 1'b0;
            bus.ocupado    <= 1'b0;
            bus.dato_leido <= '0;
        end else begin
            bus.cs_n    <= cs_n_d;
            bus.rd_n    <= rd_n_d;
            bus.wr_n    <= wr_n_d;
            bus.ad_n    <= ad_n_d;
            bus.ad_oe   <= ad_oe_d;
            bus.ad_out  <= ad_out_d;
            bus.fin     <= fin_d;
            bus.ocupado <= ocupado_d;
            if (capture) begin
                bus.dato_leido <= bus.ad_in;
            end
        end
    end
endmodule

// File: tb/tb_rtc_bus_driver.sv
// Scoreboard bench for rtc_bus_driver: stimulus pushes hand-computed expected
// transactions, a negedge monitor tracks bus phases and pops/compares on each fin.
module tb_rtc_bus_driver;
    localparam int T_PULSE = 10;
    localparam int T_GAP   = 10;
    localparam int LAT     = 31;   // acceptance edge to fin
    localparam int PERIOD  = 42;   // back-to-back acceptance spacing

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_bus_if bus ();

    rtc_bus_driver #(.T_PULSE(T_PULSE), .T_GAP(T_GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit         wr;
        logic [7:0] dir;
        logic [7:0] dato;
        logic [7:0] rd;
        int         fin_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_last_rd = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int         addr_cnt = 0, gap_cnt = 0, data_cnt = 0;
    logic [7:0] addr_val = 8'h00, data_val = 8'h00;
    bit         data_wr  = 1'b0;
    bit         fin_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            addr_cnt = 0; gap_cnt = 0; data_cnt = 0;
            fin_prev = 1'b0;
        end else begin
            check("wr_rd_overlap", 32'(!bus.wr_n && !bus.rd_n), 32'd0);
            check("oe_during_rd",  32'(!bus.rd_n && bus.ad_oe), 32'd0);
            check("fin_width",     32'(bus.fin && fin_prev),   32'd0);
            if (!bus.cs_n && !bus.ad_n) begin
                if (addr_cnt == 0) addr_val = bus.ad_out;
                else check("addr_stable", 32'(bus.ad_out), 32'(addr_val));
                addr_cnt++;
            end
            if (bus.cs_n && bus.ad_oe && !bus.fin) begin
                gap_cnt++;
                check("gap_hold", 32'(bus.ad_out), 32'(addr_val));
            end
            if (!bus.cs_n && bus.ad_n) begin
                data_cnt++;
                data_wr = !bus.wr_n;
                if (!bus.wr_n) data_val = bus.ad_out;
            end
            if (bus.fin) begin
                if (sb.size() == 0) begin
                    check("unexpected_fin", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("fin_cycle",  32'(cyc),      32'(e.fin_cyc));
                    check("addr_value", 32'(addr_val), 32'(e.dir));
                    check("addr_len",   32'(addr_cnt), 32'(T_PULSE));
                    check("gap_len",    32'(gap_cnt),  32'(T_GAP));
                    check("data_len",   32'(data_cnt), 32'(T_PULSE));
                    check("data_kind",  32'(data_wr),  32'(e.wr));
                    if (e.wr) check("data_value", 32'(data_val), 32'(e.dato));
                    check("dato_leido", 32'(bus.dato_leido), 32'(e.rd));
                end
                addr_cnt = 0; gap_cnt = 0; data_cnt = 0;
            end
            fin_prev = bus.fin;
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a negedge with the DUT idle; acceptance is the next posedge.
    task automatic issue(input bit wr, input logic [7:0] d, input logic [7:0] da,
                         input logic [7:0] rd_val, output int accept);
        exp_t e;
        bus.escribe = wr;
        bus.dir     = d;
        bus.dato    = da;
        bus.ad_in   = rd_val;
        bus.activa  = 1'b1;
        accept      = cyc + 1;
        if (!wr) exp_last_rd = rd_val;
        e.wr = wr; e.dir = d; e.dato = da; e.rd = exp_last_rd; e.fin_cyc = accept + LAT;
        sb.push_back(e);
    endtask

    task automatic wait_fin();
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.fin) found = 1'b1;
        end
        if (!found) check("fin_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] dir;
        logic [7:0] dato;
        logic [7:0] ad;
    } vec_t;

    vec_t vecs[4] = '{
        '{1'b0, 8'h7F, 8'h11, 8'hC3},
        '{1'b1, 8'hFF, 8'h00, 8'h99},
        '{1'b0, 8'h00, 8'hEE, 8'h5A},
        '{1'b1, 8'h80, 8'h01, 8'h00}
    };

    initial begin
        int  acc;
        exp_t e2;
        bit  hit;
        bus.activa = 1'b0; bus.escribe = 1'b0; bus.dir = 8'h00;
        bus.dato = 8'h00;  bus.ad_in = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n",       32'(bus.cs_n),       32'd1);
        check("rst_rd_n",       32'(bus.rd_n),       32'd1);
        check("rst_wr_n",       32'(bus.wr_n),       32'd1);
        check("rst_ad_n",       32'(bus.ad_n),       32'd1);
        check("rst_ad_oe",      32'(bus.ad_oe),      32'd0);
        check("rst_ad_out",     32'(bus.ad_out),     32'd0);
        check("rst_fin",        32'(bus.fin),        32'd0);
        check("rst_ocupado",    32'(bus.ocupado),    32'd0);
        check("rst_dato_leido", 32'(bus.dato_leido), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Write 21/45, activa held until fin.
        issue(1'b1, 8'h21, 8'h45, 8'h00, acc);
        wait_fin();
        bus.activa = 1'b0;
        repeat (15) @(negedge clk);

        // Read from 41 with the RTC returning 37.
        issue(1'b0, 8'h41, 8'h00, 8'h37, acc);
        wait_fin();
        bus.activa = 1'b0;
        repeat (15) @(negedge clk);

        // Write 22/33 with activa held; F0/F0 presented one cycle after fin.
        issue(1'b1, 8'h22, 8'h33, 8'h00, acc);
        wait_fin();
        @(negedge clk);
        bus.dir  = 8'hF0;
        bus.dato = 8'hF0;
        e2.wr = 1'b1; e2.dir = 8'hF0; e2.dato = 8'hF0; e2.rd = exp_last_rd;
        e2.fin_cyc = acc + PERIOD + LAT;
        sb.push_back(e2);
        wait_fin();
        bus.activa = 1'b0;
        repeat (15) @(negedge clk);

        // activa dropped during GAP: must still complete once, then stay idle.
        issue(1'b1, 8'h5A, 8'hA5, 8'h00, acc);
        repeat (15) @(negedge clk);
        bus.activa = 1'b0;
        wait_fin();
        repeat (60) @(negedge clk);
        check("idle_after_drop", 32'(bus.ocupado), 32'd0);
        check("no_extra_txn",    32'(sb.size()),   32'd0);

        // Reset during the DATA phase of a write: abort, no fin.
        bus.escribe = 1'b1; bus.dir = 8'h13; bus.dato = 8'h77; bus.activa = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (!bus.cs_n && bus.ad_n && !bus.wr_n) hit = 1'b1;
        end
        if (!hit) check("data_phase_timeout", 32'd1, 32'd0);
        reset = 1'b1;
        bus.activa = 1'b0;
        @(negedge clk);
        check("abort_cs_n",       32'(bus.cs_n),       32'd1);
        check("abort_wr_n",       32'(bus.wr_n),       32'd1);
        check("abort_rd_n",       32'(bus.rd_n),       32'd1);
        check("abort_ad_n",       32'(bus.ad_n),       32'd1);
        check("abort_ad_oe",      32'(bus.ad_oe),      32'd0);
        check("abort_fin",        32'(bus.fin),        32'd0);
        check("abort_ocupado",    32'(bus.ocupado),    32'd0);
        check("abort_dato_leido", 32'(bus.dato_leido), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_last_rd = 8'h00;
        repeat (50) @(negedge clk);

        // Mixed directed transactions under the monitor's invariants.
        foreach (vecs[i]) begin
            issue(vecs[i].wr, vecs[i].dir, vecs[i].dato, vecs[i].ad, acc);
            wait_fin();
            bus.activa = 1'b0;
            repeat (15) @(negedge clk);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtc_bus_driver.md
RTC_BUS_DRIVER -- requirements
Module: rtc_bus_driver

Interface
REQ-001 Parameter T_PULSE, 10, width in clk cycles of each strobe (WR/RD) pulse; legal range 1..255.
REQ-002 Parameter T_GAP, 10, clk cycles between the address and data phases and after each transaction; legal range 4..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 activa  input  1  transaction request level from the write/read sequencer.
REQ-006 escribe  input  1  1 = write transaction, 0 = read transaction; sampled at acceptance.
REQ-007 dir  input  8  RTC register address; sampled at acceptance.
REQ-008 dato  input  8  write data; sampled at acceptance.
REQ-009 ad_in  input  8  RTC multiplexed AD bus, input side.
REQ-010 ad_out  output  8  RTC AD bus, driven value.
REQ-011 ad_oe  output  1  1 = FPGA drives the AD bus; the top-level tristate uses it.
REQ-012 cs_n, rd_n, wr_n, ad_n  output  1 each  active-low chip select, read strobe, write strobe, and address/data select (0 = address).
REQ-013 fin  output  1  one-cycle completion pulse returned to the sequencer.
REQ-014 dato_leido  output  8  last byte read from the RTC.
REQ-015 ocupado  output  1  high in every state except IDLE.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have states IDLE, ADDR, GAP, DATA, DONE and RECOVER, with one 8-bit down-counter for the timed states.
REQ-018 IDLE: when activa=1 at an edge, the block SHALL latch dir, dato and escribe, load the counter, and enter ADDR; when activa=0 it SHALL remain in IDLE.
REQ-019 ADDR, T_PULSE cycles: cs_n=0, ad_n=0, wr_n=0, rd_n=1, ad_oe=1, ad_out = latched dir.
REQ-020 GAP, T_GAP cycles: cs_n=1, ad_n=1, wr_n=1, rd_n=1; ad_oe=1 and ad_out = latched dir, held for bus hold time.
REQ-021 DATA (write), T_PULSE cycles: cs_n=0, ad_n=1, wr_n=0, rd_n=1, ad_oe=1, ad_out = latched dato.
REQ-022 DATA (read), T_PULSE cycles: cs_n=0, ad_n=1, rd_n=0, wr_n=1, ad_oe=0; ad_in SHALL be captured into dato_leido on the last DATA cycle.
REQ-023 DONE, 1 cycle: all strobes high, cs_n=1, fin=1; ad_oe stays 1 for a write and 0 for a read.
REQ-024 RECOVER, T_GAP cycles: fin=0, ad_oe=0, ad_out=0, all strobes high; then the FSM SHALL return to IDLE.
REQ-025 In RECOVER the block SHALL ignore activa, so a request held high across fin, or re-asserted with new dir/dato within 3 cycles of fin, is accepted only after RECOVER ends, using the values present at that time.
REQ-026 Once accepted, a transaction SHALL complete regardless of later changes to activa, escribe, dir or dato.
REQ-027 fin SHALL be high for exactly one cycle per accepted transaction and never otherwise.
REQ-028 Transaction length from acceptance edge to fin: 1 + T_PULSE + T_GAP + T_PULSE cycles; the back-to-back period SHALL be that value + 1 + T_GAP.
REQ-029 wr_n and rd_n SHALL never be low simultaneously, and ad_oe SHALL be 0 whenever rd_n=0.
REQ-030 dato_leido SHALL change only on the read-capture cycle and SHALL hold its value across write transactions.
REQ-031 An illegal state SHALL return to IDLE on the next edge with all outputs at their reset values.

Reset
REQ-032 While reset=1 at an edge: state=IDLE, counter=0, cs_n=rd_n=wr_n=ad_n=1, ad_oe=0, ad_out=0, fin=0, ocupado=0, dato_leido=0.
REQ-033 Reset asserted mid-transaction SHALL abort it on the next edge with no fin pulse; reset has priority over all other inputs.

Verification
REQ-034 Parameters T_PULSE=10 and T_GAP=10; write with dir=8'h21, dato=8'h45, activa held -> AD=21 while ad_n=0 and wr_n=0 for 10 cycles; AD=45 while wr_n=0 for 10 cycles; fin pulses at cycle 31 after acceptance.
REQ-035 Read with dir=8'h41, escribe=0, ad_in=8'h37 during DATA -> ad_oe=0 while rd_n=0, dato_leido=8'h37, fin pulses once.
REQ-036 Write to 8'h22, then within 2 cycles of fin the sequencer presents dir=dato=8'hF0 with activa still high -> second transaction starts exactly when RECOVER ends and carries F0/F0, with no duplicate 8'h22 cycle.
REQ-037 Reset pulsed during the DATA phase of a write -> next edge has all strobes high and ad_oe=0, no fin pulse, ocupado=0.
REQ-038 activa deasserted during GAP -> transaction completes, fin pulses once, then the block stays in IDLE.
REQ-039 Random transactions with an assertion monitor -> wr_n and rd_n are never both 0, ad_oe=0 whenever rd_n=0, and every fin is exactly one cycle wide.
